data_receiver: RTL and testbench

//  UART receiver paired with DataTransmitter. Deserialises 8N1 frames from i_rxd and assembles

---
 rtl/data_receiver_pkg.sv | 44 ++++
 rtl/data_receiver_uart_rx_byte.sv | 91 +++++++++
 rtl/data_receiver.sv | 103 ++++++++++
 tb/tb_data_receiver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_receiver_pkg.sv
// Shared types and helpers for the UART word receiver: bit-FSM states, ASCII constants and
// the hex-digit decoder.
package data_receiver_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    localparam logic [7:0] AsciiZero   = 8'h30;
    localparam logic [7:0] AsciiNine   = 8'h39;
    localparam logic [7:0] AsciiUpperA = 8'h41;
    localparam logic [7:0] AsciiUpperF = 8'h46;
    localparam logic [7:0] AsciiLowerA = 8'h61;
    localparam logic [7:0] AsciiLowerF = 8'h66;
    localparam logic [7:0] AsciiCr     = 8'h0D;
    localparam logic [7:0] AsciiLf     = 8'h0A;
    localparam logic [7:0] AsciiSpace  = 8'h20;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } nibble_t;

    function automatic nibble_t ascii_to_nibble(input logic [7:0] c);
        nibble_t r;
        r.valid  = 1'b1;
        r.nibble = 4'h0;
        if (c >= AsciiZero && c <= AsciiNine) begin
            r.nibble = 4'(c - AsciiZero);
        end else if (c >= AsciiUpperA && c <= AsciiUpperF) begin
            r.nibble = 4'(c - AsciiUpperA + 8'd10);
        end else if (c >= AsciiLowerA && c <= AsciiLowerF) begin
            r.nibble = 4'(c - AsciiLowerA + 8'd10);
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_receiver_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF input synchroniser plus a bit-timing FSM with registered
// byte strobe and frame-error pulse.
module uart_rx_byte
    import data_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 723
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TFull = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] THalf = TW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    rx_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q;
    logic          frame_err_q;
    logic          rxd_s;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync_q       <= 2'b11;
            state_q      <= StIdle;
            timer_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], i_rxd};
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            timer_q      <= timer_q + 1'b1;
            case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    if (!rxd_s) state_q <= StStart;
                end
                StStart: begin
                    // Re-check mid start bit so short low glitches are rejected.
                    if (timer_q == THalf) begin
                        timer_q <= '0;
                        bit_q   <= '0;
                        state_q <= rxd_s ? StIdle : StData;
                    end
                end
                StData: begin
                    if (timer_q == TFull) begin
                        timer_q <= '0;
                        shift_q <= {rxd_s, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= StStop;
                    end
                end
                StStop: begin
                    if (timer_q == TFull) begin
                        timer_q <= '0;
                        if (rxd_s) begin
                            byte_valid_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    timer_q <= '0;
                    if (rxd_s) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_byte       = shift_q;
    assign o_byte_valid = byte_valid_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: rtl/data_receiver.sv
// UART word receiver: assembles raw bytes or ASCII hex digits from uart_rx_byte into one
// DATA_WIDTH word and pulses o_data_valid when it completes.
module data_receiver
    import data_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned CLKS_PER_BIT = 723
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_rxd,
    input  logic                  i_hex,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_frame_err
);

    localparam int unsigned NumBytes  = DATA_WIDTH / 8;
    localparam int unsigned NumDigits = DATA_WIDTH / 4;
    localparam int unsigned CW        = $clog2(NumDigits) + 1;
    localparam logic [CW-1:0] LastByte  = CW'(NumBytes - 1);
    localparam logic [CW-1:0] LastDigit = CW'(NumDigits - 1);

    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic                  rx_frame_err;
    logic                  hex_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  accept;
    logic                  last;
    nibble_t               nib;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rxd       (i_rxd),
        .o_byte      (rx_byte),
        .o_byte_valid(rx_valid),
        .o_frame_err (rx_frame_err)
    );

    always_comb begin
        nib     = ascii_to_nibble(rx_byte);
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        // Flush and mode change both override a same-cycle byte strobe.
        if (i_flush || (i_hex != hex_q)) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (rx_valid) begin
            if (!hex_q) begin
                accept = 1'b1;
                last   = (cnt_q == LastByte);
                shift_d[8*int'(cnt_q) +: 8] = rx_byte;
            end else begin
                accept = nib.valid;
                last   = (cnt_q == LastDigit);
                if (nib.valid) shift_d = {shift_q[DATA_WIDTH-5:0], nib.nibble};
            end
            if (accept) begin
                if (last) begin
                    data_d  = shift_d;
                    valid_d = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            hex_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hex_q   <= i_hex;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_frame_err  = rx_frame_err;

endmodule

// File: tb/tb_data_receiver.sv
// Directed-plus-random bench for data_receiver driving a bit-accurate 8N1 line model.
module tb_data_receiver;

    localparam int unsigned W   = 128;
    localparam int unsigned CPB = 16;

    typedef logic [7:0] bytes_t[$];

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_rxd;
    logic         i_hex;
    logic         i_flush;
    logic [W-1:0] o_data;
    logic         o_data_valid;
    logic         o_frame_err;

    int           n_vec = 0;
    int           n_err = 0;
    int           nv = 0;
    int           nf = 0;
    bit           both = 1'b0;
    logic [W-1:0] cap = '0;

    always #5 clk = ~clk;

    data_receiver #(
        .DATA_WIDTH  (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rxd       (i_rxd),
        .i_hex       (i_hex),
        .i_flush     (i_flush),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_frame_err (o_frame_err)
    );

    // Output monitor: counts pulses and captures the delivered word.
    always @(posedge clk) begin
        #1;
        if (o_data_valid) begin
            nv  <= nv + 1;
            cap <= o_data;
        end
        if (o_frame_err) nf <= nf + 1;
        if (o_data_valid && o_frame_err) both <= 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        i_rxd = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            i_rxd = b[i];
            wait_clk(CPB);
        end
        i_rxd = stop_ok;
        wait_clk(CPB);
        if (stop_ok) wait_clk(2);
    endtask

    task automatic send_q(input bytes_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    function automatic logic [W-1:0] raw_model(input bytes_t q);
        logic [W-1:0] w = '0;
        foreach (q[k]) w = w | (W'(q[k]) << (8 * k));
        return w;
    endfunction

    // Hex digits accumulate as a base-16 number, first digit most significant.
    function automatic logic [W-1:0] hex_model(input bytes_t q);
        logic [W-1:0] w = '0;
        int           d;
        foreach (q[i]) begin
            d = -1;
            if (q[i] >= "0" && q[i] <= "9") d = int'(q[i]) - 48;
            else if (q[i] >= "A" && q[i] <= "F") d = int'(q[i]) - 65 + 10;
            else if (q[i] >= "a" && q[i] <= "f") d = int'(q[i]) - 97 + 10;
            if (d >= 0) w = w * 16 + W'(d);
        end
        return w;
    endfunction

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic bytes_t rand_hex();
        bytes_t q;
        string  digits = "0123456789ABCDEFabcdef";
        string  seps   = " \n:";
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 3) == 0) q.push_back(8'h0D);
                else q.push_back(seps[$urandom_range(0, 2)]);
            end
            q.push_back(digits[$urandom_range(0, 21)]);
        end
        return q;
    endfunction

    initial begin
        bytes_t q;
        string  s;
        int     nv0;
        int     nf0;

        i_rst   = 1'b1;
        i_rxd   = 1'b1;
        i_hex   = 1'b0;
        i_flush = 1'b0;
        wait_clk(4);
        chk("reset_data", o_data, '0);
        chk("reset_valid", W'(o_data_valid), '0);
        chk("reset_ferr", W'(o_frame_err), '0);
        i_rst = 1'b0;
        wait_clk(8);

        // Raw mode, directed 00..0F
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        nv0 = nv;
        nf0 = nf;
        send_q(q);
        wait_clk(4);
        chk("raw_count", W'(nv - nv0), W'(1));
        chk("raw_word", cap, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // Raw mode, random
        q   = rand_bytes(16);
        nv0 = nv;
        send_q(q);
        wait_clk(4);
        chk("raw_rand_count", W'(nv - nv0), W'(1));
        chk("raw_rand_word", cap, raw_model(q));
        chk("raw_no_ferr", W'(nf - nf0), '0);

        // Hex mode, directed string with separators
        i_hex = 1'b1;
        wait_clk(4);
        s = "0123456789ABCDEF fedcba9876543210";
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        nv0 = nv;
        send_q(q);
        wait_clk(4);
        chk("hex_count", W'(nv - nv0), W'(1));
        chk("hex_word", cap, 128'h0123456789ABCDEFFEDCBA9876543210);

        // Hex mode, random digits and separators
        q   = rand_hex();
        nv0 = nv;
        send_q(q);
        wait_clk(4);
        chk("hex_rand_count", W'(nv - nv0), W'(1));
        chk("hex_rand_word", cap, hex_model(q));

        // Frame error then held-low break
        i_hex = 1'b0;
        wait_clk(4);
        nv0 = nv;
        nf0 = nf;
        send_byte(8'h55, 1'b0);
        wait_clk(40 * CPB);
        i_rxd = 1'b1;
        wait_clk(4 * CPB);
        chk("ferr_pulse", W'(nf - nf0), W'(1));
        chk("ferr_no_valid", W'(nv - nv0), '0);
        q = rand_bytes(16);
        send_q(q);
        wait_clk(4);
        chk("ferr_after_count", W'(nv - nv0), W'(1));
        chk("ferr_after_word", cap, raw_model(q));

        // Short start-bit glitch
        nv0   = nv;
        nf0   = nf;
        i_rxd = 1'b0;
        wait_clk(4);
        i_rxd = 1'b1;
        wait_clk(3 * CPB);
        chk("glitch_no_valid", W'(nv - nv0), '0);
        chk("glitch_no_ferr", W'(nf - nf0), '0);
        q = rand_bytes(16);
        send_q(q);
        wait_clk(4);
        chk("glitch_after_count", W'(nv - nv0), W'(1));
        chk("glitch_after_word", cap, raw_model(q));

        // Flush after 10 raw bytes
        nv0 = nv;
        send_q(rand_bytes(10));
        i_flush = 1'b1;
        wait_clk(1);
        i_flush = 1'b0;
        q = rand_bytes(16);
        send_q(q);
        wait_clk(4);
        chk("flush_count", W'(nv - nv0), W'(1));
        chk("flush_word", cap, raw_model(q));

        // Mode toggle after 5 hex digits discards them
        i_hex = 1'b1;
        wait_clk(4);
        nv0 = nv;
        s   = "3A7f9";
        q   = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        send_q(q);
        i_hex = 1'b0;
        wait_clk(3);
        i_hex = 1'b1;
        wait_clk(3);
        q = rand_hex();
        send_q(q);
        wait_clk(4);
        chk("toggle_count", W'(nv - nv0), W'(1));
        chk("toggle_word", cap, hex_model(q));

        // Reset in the middle of the third byte
        i_hex = 1'b0;
        wait_clk(4);
        nf0 = nf;
        send_q(rand_bytes(2));
        i_rxd = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 3; i++) begin
            i_rxd = 1'(i & 1);
            wait_clk(CPB);
        end
        i_rst = 1'b1;
        i_rxd = 1'b1;
        wait_clk(3);
        chk("midrst_data", o_data, '0);
        chk("midrst_valid", W'(o_data_valid), '0);
        i_rst = 1'b0;
        wait_clk(2 * CPB);
        nv0 = nv;
        q   = rand_bytes(16);
        send_q(q);
        wait_clk(4);
        chk("midrst_count", W'(nv - nv0), W'(1));
        chk("midrst_word", cap, raw_model(q));
        chk("midrst_no_ferr", W'(nf - nf0), '0);

        chk("valid_ferr_exclusive", W'(both), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
